// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared stage-state encoding and saturating-counter helper
// Contents: ps_state_t (PS_EMPTY/PS_ONE/PS_FULL), CNT_W, sat_inc()
package pipe_stage_reg_pkg;
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } ps_state_t;
    localparam int CNT_W = 32;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && c != '1) ? c + 1'b1 : c;
    endfunction
endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one {valid, ctrl, data} register with load and clear
// Ports: clk, rst (sync, active-high, zeroes everything), ld, clr (drops valid/ctrl, keeps data),
//        d_ctrl/d_data (load value), valid/ctrl/data (held entry)
module pipe_slot #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              clr,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (ld) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline-stage register with flush, bubble and optional skid slot
// Ports: clk, rst (sync, active-high), flush, bubble, in_valid/in_ready/in_ctrl/in_data (upstream),
//        out_valid/out_ready/out_ctrl/out_data (downstream)
// `PIPE_PERF_EN adds stall_cnt, bubble_cnt, flush_cnt (32-bit saturating counters)
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 4,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              bubble,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);
    ps_state_t         state, state_n;
    logic              in_fire, out_fire, main_ld, main_clr, skid_v;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    // with a skid slot, in_ready depends only on registered state, never on out_ready
    assign in_ready = ~rst & ~bubble & ((SKID != 0) ? (state != PS_FULL) : (~out_valid | out_ready));
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_ctrl = out_valid ? main_ctrl : '0;
    always_ff @(posedge clk) begin
        if (rst || flush) state <= PS_EMPTY;
        else state <= state_n;
    end
    always_comb begin
        state_n = (state == PS_EMPTY) ? (in_fire ? PS_ONE : PS_EMPTY)
                : (state == PS_ONE)   ? ((in_fire & ~out_fire) ? PS_FULL : (out_fire & ~in_fire) ? PS_EMPTY : PS_ONE)
                :                       (out_fire ? PS_ONE : PS_FULL);
    end
    // a held skid entry is older than anything new, so it refills main first
    assign main_ld  = skid_v ? out_fire : in_fire & ((state == PS_EMPTY) | out_fire);
    assign main_clr = flush | (out_fire & ~main_ld);
    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .ld     (main_ld),
        .clr    (main_clr),
        .d_ctrl (skid_v ? skid_ctrl : in_ctrl),
        .d_data (skid_v ? skid_data : in_data),
        .valid  (out_valid),
        .ctrl   (main_ctrl),
        .data   (out_data)
    );
    if (SKID != 0) begin : g_skid
        logic skid_ld;
        assign skid_ld = in_fire & (state == PS_ONE) & ~out_fire;
        pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
            .clk    (clk),
            .rst    (rst),
            .ld     (skid_ld),
            .clr    (flush | out_fire),
            .d_ctrl (in_ctrl),
            .d_data (in_data),
            .valid  (skid_v),
            .ctrl   (skid_ctrl),
            .data   (skid_data)
        );
    end else begin : g_noskid
        assign skid_v    = 1'b0;
        assign skid_ctrl = '0;
        assign skid_data = '0;
    end
`ifdef PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            stall_cnt  <= sat_inc(stall_cnt, in_valid & ~in_ready);
            bubble_cnt <= sat_inc(bubble_cnt, ~out_valid);
            flush_cnt  <= sat_inc(flush_cnt, flush & (out_valid | in_fire));
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench running SKID=1 and SKID=0 stages side by side against a FIFO model
module tb_pipe_stage_reg;
    localparam int DW = 16;
    localparam int CW = 4;
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;
    logic          clk = 1'b0;
    logic          rst = 1'b1, flush = 1'b0, bubble = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          rdy [2];
    logic          ov  [2];
    logic [CW-1:0] oc  [2];
    logic [DW-1:0] od  [2];
    logic          was_rst = 1'b0;
    ent_t          q [2][$];
    int            checks = 0, errors = 0;
`ifdef PIPE_PERF_EN
    logic [31:0]   sc [2], bc [2], fc [2];
    int            m_stall [2], m_bub [2], m_fl [2];
`endif
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(g)) dut (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .bubble    (bubble),
            .in_valid  (in_valid),
            .in_ready  (rdy[g]),
            .in_ctrl   (in_ctrl),
            .in_data   (in_data),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_ctrl  (oc[g]),
            .out_data  (od[g])
`ifdef PIPE_PERF_EN
            ,
            .stall_cnt  (sc[g]),
            .bubble_cnt (bc[g]),
            .flush_cnt  (fc[g])
`endif
        );
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // model side: every entry the stage accepts is expected, in order, at the output
    always @(posedge clk) begin
        was_rst <= rst;
        for (int k = 0; k < 2; k++)
            if (in_valid && rdy[k] && !flush && !rst) q[k].push_back('{c: in_ctrl, d: in_data});
    end
    // monitor: queue occupancy is the stage occupancy; front of queue is what must be shown
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic exp_rdy;
            exp_rdy = !rst && !bubble && (k == 1 ? q[k].size() < 2 : (q[k].size() == 0 || out_ready));
            chk($sformatf("in_ready[skid=%0d]", k), 64'(rdy[k]), 64'(exp_rdy));
            chk($sformatf("out_valid[skid=%0d]", k), 64'(ov[k]), 64'(q[k].size() > 0));
            if (ov[k] && q[k].size() > 0) begin
                chk($sformatf("out_data[skid=%0d]", k), 64'(od[k]), 64'(q[k][0].d));
                chk($sformatf("out_ctrl[skid=%0d]", k), 64'(oc[k]), 64'(q[k][0].c));
            end else if (!ov[k]) begin
                chk($sformatf("nop_ctrl[skid=%0d]", k), 64'(oc[k]), 64'd0);
            end
            if (was_rst) chk($sformatf("reset_data[skid=%0d]", k), 64'(od[k]), 64'd0);
            if (rst) begin
                q[k].delete();
`ifdef PIPE_PERF_EN
                m_stall[k] = 0; m_bub[k] = 0; m_fl[k] = 0;
`endif
            end else begin
`ifdef PIPE_PERF_EN
                if (in_valid && !rdy[k]) m_stall[k]++;
                if (!ov[k]) m_bub[k]++;
                if (flush && (q[k].size() > 0 || (in_valid && rdy[k]))) m_fl[k]++;
`endif
                if (flush) q[k].delete();
                else if (ov[k] && out_ready && q[k].size() > 0) void'(q[k].pop_front());
            end
        end
    end
    task automatic cyc(input logic iv, input logic ordy, input logic fl, input logic bub, input logic r);
        @(posedge clk);
        #1;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        bubble    = bub;
        rst       = r;
        in_data   = DW'($urandom);
        in_ctrl   = CW'($urandom);
    endtask
    initial begin
        repeat (2) cyc(0, 1, 0, 0, 1);
        repeat (8) cyc(1, 1, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0);
        repeat (2) cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 1, 0);
        repeat (3) cyc(1, 1, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0);
        repeat (2) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        repeat (2) cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, logic'(i % 2 == 0), 0, 0, 0);
        cyc(1, 0, 1, 1, 0);
        repeat (2) cyc(0, 1, 0, 0, 0);
        repeat (600) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                         $urandom_range(0, 30) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 120) == 0);
        repeat (4) cyc(0, 1, 0, 0, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
`ifdef PIPE_PERF_EN
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("stall_cnt[skid=%0d]", k), 64'(sc[k]), 64'(m_stall[k]));
            chk($sformatf("bubble_cnt[skid=%0d]", k), 64'(bc[k]), 64'(m_bub[k]));
            chk($sformatf("flush_cnt[skid=%0d]", k), 64'(fc[k]), 64'(m_fl[k]));
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
